// File: rtl/sdff_bank_pkg.sv
`default_nettype none
// ============================================================================
// sdff_bank_pkg : shared types and helpers for the scan register bank
// Rev 1.0
// ============================================================================
package sdff_bank_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } unload_state_t;

  // Unload counter width; a 1-bit bank still gets a 1-bit counter.
  function automatic int cnt_width(input int width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

endpackage : sdff_bank_pkg
`default_nettype wire

// File: rtl/sdff_bank_unload_ctl.sv
`default_nettype none
// ============================================================================
// sdff_bank_unload_ctl : self-timed unload FSM (IDLE/SHIFT/DONE) and counter
// Rev 1.0
// ============================================================================
module sdff_bank_unload_ctl
  import sdff_bank_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_abort,
  input  logic i_req,
  output logic o_shift_en,
  output logic o_busy,
  output logic o_done
);

  localparam int                 c_cnt_w = cnt_width(WIDTH);
  localparam logic [c_cnt_w-1:0] c_last  = c_cnt_w'(WIDTH - 1);
  localparam logic [c_cnt_w-1:0] c_one   = c_cnt_w'(1);

  unload_state_t      state_q, state_d;
  logic [c_cnt_w-1:0] cnt_q, cnt_d;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (i_req) begin
          state_d = SHIFT;
          cnt_d   = '0;
        end
      end
      SHIFT: begin
        // Hold the count on the terminal shift so it never wraps.
        if (cnt_q == c_last) begin
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + c_one;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    // Set aborts any unload in progress without producing a DONE pulse.
    if (i_abort) begin
      state_d = IDLE;
      cnt_d   = '0;
    end
  end

  assign o_shift_en = (state_q == SHIFT);
  assign o_busy     = (state_q == SHIFT);
  assign o_done     = (state_q == DONE);

endmodule : sdff_bank_unload_ctl
`default_nettype wire

// File: rtl/sdff_scan_bank.sv
`default_nettype none
// ============================================================================
// sdff_scan_bank : WIDTH-bit muxed-scan register bank with sync reset/set,
//                  capture enable and a self-timed MSB-first unload engine
// Rev 1.0
// ============================================================================
module sdff_scan_bank
  import sdff_bank_pkg::*;
#(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}},
  parameter logic [WIDTH-1:0] SET_VAL   = {WIDTH{1'b1}}
) (
  input  logic             CK,
  input  logic             RST,
  input  logic             SN,
  input  logic             EN,
  input  logic [WIDTH-1:0] D,
  input  logic             SE,
  input  logic             SI,
  output logic             SO,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] QN,
  input  logic             UNLOAD_REQ,
  output logic             UNLOAD_BUSY,
  output logic             UNLOAD_DONE
);

  logic [WIDTH-1:0] bank_q, bank_d;
  logic [WIDTH-1:0] w_shift_val;
  logic             w_abort;
  logic             w_auto_shift;

  assign w_abort = ~SN;

  sdff_bank_unload_ctl #(
    .WIDTH (WIDTH)
  ) u_unload_ctl (
    .i_clk      (CK),
    .i_rst      (RST),
    .i_abort    (w_abort),
    .i_req      (UNLOAD_REQ),
    .o_shift_en (w_auto_shift),
    .o_busy     (UNLOAD_BUSY),
    .o_done     (UNLOAD_DONE)
  );

  generate
    if (WIDTH == 1) begin : g_shift_w1
      assign w_shift_val = SI;
    end else begin : g_shift_wn
      assign w_shift_val = {bank_q[WIDTH-2:0], SI};
    end
  endgenerate

  // Auto-unload shifting outranks SE/EN, so both are ignored while busy.
  always_comb begin
    bank_d = bank_q;
    if (!SN) begin
      bank_d = SET_VAL;
    end else if (w_auto_shift || SE) begin
      bank_d = w_shift_val;
    end else if (EN) begin
      bank_d = D;
    end
  end

  always_ff @(posedge CK) begin
    if (RST) begin
      bank_q <= RESET_VAL;
    end else begin
      bank_q <= bank_d;
    end
  end

  assign Q  = bank_q;
  assign QN = ~bank_q;
  assign SO = bank_q[WIDTH-1];

endmodule : sdff_scan_bank
`default_nettype wire
